// File: rtl/paint_pkg.sv
// Shared definitions for the paint command sequencer.
// Holds the FSM state encoding, the command opcodes, the default
// screen geometry and a small opcode-classification helper.
package paint_pkg;

   localparam int SCR_W_DEF = 640;
   localparam int SCR_H_DEF = 480;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_EXEC  = 3'd3,
      ST_DRAW  = 3'd4
   } state_t;

   localparam logic [3:0] OP_NOP      = 4'h0;
   localparam logic [3:0] OP_SETCOLOR = 4'h1;
   localparam logic [3:0] OP_MOVE     = 4'h2;
   localparam logic [3:0] OP_PIXEL    = 4'h3;
   localparam logic [3:0] OP_HLINE    = 4'h4;
   localparam logic [3:0] OP_RECT     = 4'h5;

   function automatic logic is_draw_op(input logic [3:0] op);
      return (op == OP_PIXEL) || (op == OP_HLINE) || (op == OP_RECT);
   endfunction

endpackage

// File: rtl/paint_walker.sv
// Row-major pixel walker with screen clipping.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   start             - load origin/size and begin walking (width, height > 0)
//   x0, y0            - origin of the area to walk
//   width, height     - area size in pixels
//   px_ready          - downstream accepts the presented pixel
//   px_valid          - a visible pixel is presented
//   px_x, px_y        - coordinates of the presented pixel
//   done              - one-cycle pulse as the last pixel is transferred or clipped
module paint_walker
   import paint_pkg::*;
#(
   parameter int SCR_W = SCR_W_DEF,
   parameter int SCR_H = SCR_H_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [9:0] x0,
   input  logic [8:0] y0,
   input  logic [9:0] width,
   input  logic [8:0] height,
   input  logic       px_ready,
   output logic       px_valid,
   output logic [9:0] px_x,
   output logic [8:0] px_y,
   output logic       done
);

   logic       active_reg;
   logic [9:0] x0_reg;
   logic [9:0] w_reg;
   logic [9:0] col_reg;
   logic [8:0] y0_reg;
   logic [8:0] h_reg;
   logic [8:0] row_reg;

   logic [10:0] x_full;
   logic [9:0]  y_full;
   logic        clipped;
   logic        advance;
   logic        last_col;
   logic        last_row;

   // One extra bit on each axis so a pixel past the right/bottom edge is
   // seen as out of range instead of wrapping back onto the screen.
   assign x_full   = {1'b0, x0_reg} + {1'b0, col_reg};
   assign y_full   = {1'b0, y0_reg} + {1'b0, row_reg};
   assign clipped  = (x_full >= 11'(SCR_W)) || (y_full >= 10'(SCR_H));

   // Outputs come straight from registers, so they hold while stalled.
   assign px_valid = active_reg && !clipped;
   assign px_x     = x_full[9:0];
   assign px_y     = y_full[8:0];

   // A clipped pixel consumes its cycle without waiting for px_ready.
   assign advance  = active_reg && (clipped || px_ready);
   assign last_col = (col_reg == w_reg - 10'd1);
   assign last_row = (row_reg == h_reg - 9'd1);
   assign done     = advance && last_col && last_row;

   always_ff @(posedge clk) begin
      if (reset) begin
         active_reg <= 1'b0;
         x0_reg     <= '0;
         y0_reg     <= '0;
         w_reg      <= '0;
         h_reg      <= '0;
         col_reg    <= '0;
         row_reg    <= '0;
      end else if (start) begin
         active_reg <= 1'b1;
         x0_reg     <= x0;
         y0_reg     <= y0;
         w_reg      <= width;
         h_reg      <= height;
         col_reg    <= '0;
         row_reg    <= '0;
      end else if (advance) begin
         if (last_col) begin
            col_reg <= '0;
            if (last_row) begin
               active_reg <= 1'b0;
            end else begin
               row_reg <= row_reg + 9'd1;
            end
         end else begin
            col_reg <= col_reg + 10'd1;
         end
      end
   end

endmodule

// File: rtl/paint_cmd_sequencer.sv
// Paint command sequencer: fetches 32-bit commands from a queue, keeps
// the pen state (color, cursor) and streams clipped pixels out through a
// valid/ready handshake.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   q_empty, q_re, q_data       - command queue (data valid the cycle after q_re)
//   halt                        - blocks new fetches; current command completes
//   px_valid, px_ready          - pixel write handshake
//   px_x, px_y, px_color        - pixel payload
//   busy                        - high whenever not idle
//   err                         - sticky illegal-opcode flag
//   cmd_count                   - retired command counter (wraps)
module paint_cmd_sequencer
   import paint_pkg::*;
#(
   parameter int SCR_W = SCR_W_DEF,
   parameter int SCR_H = SCR_H_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        q_empty,
   output logic        q_re,
   input  logic [31:0] q_data,
   input  logic        halt,
   output logic        px_valid,
   input  logic        px_ready,
   output logic [9:0]  px_x,
   output logic [8:0]  px_y,
   output logic [7:0]  px_color,
   output logic        busy,
   output logic        err,
   output logic [15:0] cmd_count
);

   state_t state_reg;
   state_t state_next;

   logic [31:0] cmd_reg;
   logic [7:0]  color_reg;
   logic [9:0]  cx_reg;
   logic [8:0]  cy_reg;
   logic        err_reg;
   logic [15:0] count_reg;

   logic [3:0] opcode;
   logic [9:0] cmd_width;
   logic [8:0] cmd_height;
   logic       draw_op;
   logic       empty_draw;
   logic       walk_start;
   logic       walk_done;
   logic       retire;
   logic       unused_cmd_bits;

   assign opcode  = cmd_reg[31:28];
   assign draw_op = is_draw_op(opcode);
   assign unused_cmd_bits = ^{cmd_reg[27:26], cmd_reg[15:10]};

   always_comb begin
      cmd_width  = cmd_reg[9:0];
      cmd_height = 9'd1;
      if (opcode == OP_PIXEL) cmd_width = 10'd1;
      if (opcode == OP_RECT)  cmd_height = cmd_reg[24:16];
   end

   assign empty_draw = (cmd_width == 10'd0) || (cmd_height == 9'd0);

   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      q_re       = 1'b0;
      walk_start = 1'b0;
      retire     = 1'b0;
      case (state_reg)
         ST_IDLE:  if (!q_empty && !halt) state_next = ST_FETCH;
         ST_FETCH: begin
            q_re       = 1'b1;
            state_next = ST_LATCH;
         end
         ST_LATCH: state_next = ST_EXEC;
         ST_EXEC: begin
            if (draw_op && !empty_draw) begin
               walk_start = 1'b1;
               state_next = ST_DRAW;
            end else begin
               retire     = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_DRAW: begin
            if (walk_done) begin
               retire     = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_reg   <= '0;
         color_reg <= '0;
         cx_reg    <= '0;
         cy_reg    <= '0;
         err_reg   <= 1'b0;
         count_reg <= '0;
      end else begin
         if (state_reg == ST_LATCH) cmd_reg <= q_data;
         if (state_reg == ST_EXEC) begin
            case (opcode)
               OP_NOP, OP_PIXEL, OP_HLINE, OP_RECT: ;
               OP_SETCOLOR: color_reg <= cmd_reg[7:0];
               OP_MOVE: begin
                  cx_reg <= cmd_reg[25:16];
                  cy_reg <= cmd_reg[8:0];
               end
               default: err_reg <= 1'b1;
            endcase
         end
         // Lines and single pixels advance the cursor past what was drawn;
         // rectangles leave it at their origin. Wraps at 1024.
         if (state_reg == ST_DRAW && walk_done && opcode != OP_RECT)
            cx_reg <= cx_reg + cmd_width;
         if (retire) count_reg <= count_reg + 16'd1;
      end
   end

   paint_walker #(
      .SCR_W(SCR_W),
      .SCR_H(SCR_H)
   ) u_walker (
      .clk      (clk),
      .reset    (reset),
      .start    (walk_start),
      .x0       (cx_reg),
      .y0       (cy_reg),
      .width    (cmd_width),
      .height   (cmd_height),
      .px_ready (px_ready),
      .px_valid (px_valid),
      .px_x     (px_x),
      .px_y     (px_y),
      .done     (walk_done)
   );

   assign px_color  = color_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign err       = err_reg;
   assign cmd_count = count_reg;

endmodule

// File: doc/paint_cmd_sequencer.md
PAINT_CMD_SEQUENCER -- requirements
Module: paint_cmd_sequencer

Interface
REQ-001 SHALL have parameter SCR_W, default 640, meaning visible pixel columns.
REQ-002 SHALL have parameter SCR_H, default 480, meaning visible pixel rows.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port q_empty, input, 1, command queue empty flag.
REQ-006 SHALL have port q_re, output, 1, queue read enable.
REQ-007 SHALL have port q_data, input, 32, queue read data, valid the cycle after q_re.
REQ-008 SHALL have port halt, input, 1, blocks new fetches; the current command completes.
REQ-009 SHALL have ports px_valid (output, 1), px_ready (input, 1), px_x (output, 10), px_y (output, 9) and px_color (output, 8), forming the pixel write handshake.
REQ-010 SHALL have ports busy (output, 1), err (output, 1, sticky illegal-opcode flag) and cmd_count (output, 16, number of commands retired).

Function
REQ-011 SHALL implement states IDLE, FETCH, LATCH, EXEC and DRAW.
REQ-012 SHALL move IDLE->FETCH when q_empty=0 and halt=0, otherwise stay in IDLE.
REQ-013 SHALL assert q_re only in FETCH, for exactly one cycle per command; FETCH->LATCH unconditionally.
REQ-014 SHALL register q_data into the command register in LATCH; LATCH->EXEC.
REQ-015 SHALL decode opcode cmd[31:28] in EXEC as follows:
- 0x0 NOP: no effect.
- 0x1 SETCOLOR: color<=cmd[7:0].
- 0x2 MOVE: cx<=cmd[25:16], cy<=cmd[8:0].
- 0x3 PIXEL: 1x1 draw.
- 0x4 HLINE: width=cmd[9:0], height 1.
- 0x5 RECT: width=cmd[9:0], height=cmd[24:16].
- Others: set err, no other effect.
REQ-016 SHALL have non-draw opcodes, and draw opcodes with width=0 or height=0, go EXEC->IDLE and increment cmd_count.
REQ-017 SHALL walk pixels in DRAW row-major, starting at (cx,cy): x from cx to cx+width-1, then y+1.
REQ-018 SHALL hold px_valid, px_x, px_y and px_color stable until px_ready=1; a pixel is transferred on the cycle where px_valid and px_ready are both 1.
REQ-019 SHALL skip, without asserting px_valid, any pixel with x>=SCR_W or y>=SCR_H (clipped); each skipped pixel consumes one cycle.
REQ-020 SHALL compute pixel coordinates in 11-bit (x) and 10-bit (y) arithmetic so that no wrap occurs before the clip test.
REQ-021 SHALL, after a transfer or clip of the last pixel, go DRAW->IDLE and increment cmd_count (wrapping mod 2^16).
REQ-022 SHALL, after the command completes, leave cx=(cx+width) mod 1024 for PIXEL and HLINE; RECT leaves cx and cy unchanged.
REQ-023 SHALL have zero idle cycles between px_valid pulses when px_ready is held at 1.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL, when halt rises mid-command, not abort; the halt takes effect only in IDLE.

Reset
REQ-026 SHALL, on reset, drive state=IDLE, q_re=0, px_valid=0, px_x=0, px_y=0, px_color=0, color=0, cx=0, cy=0, err=0, cmd_count=0 and busy=0.
REQ-027 SHALL, on reset mid-DRAW, drop px_valid the next cycle and discard the remaining pixels; the queue entry is not re-fetched.

Structure
REQ-028 SHALL take opcode constants, the state encoding, and the SCR_W/SCR_H defaults from the shared package paint_pkg.
REQ-029 SHALL place the row-major coordinate walker with clip test in one sub-module, paint_walker.

Verification
REQ-030 SHALL verify: SETCOLOR 0x1000_00AB, MOVE 0x2005_0007, PIXEL 0x3000_0000 with px_ready=1 -> one px_valid with (5,7,0xAB); q_re observed exactly 3 times.
REQ-031 SHALL verify: RECT width=3 height=2 at (10,20) with px_ready=1 -> 6 consecutive pixels (10..12,20),(10..12,21); cx=10, cy=20 after.
REQ-032 SHALL verify: HLINE width=4 at (638,0) -> pixels only at x=638 and 639, 2 clipped cycles, cx=642 after.
REQ-033 SHALL verify: px_ready=0 for 5 cycles during HLINE -> px_x, px_y and px_color held constant; no pixel lost or duplicated.
REQ-034 SHALL verify: opcode 0xF, then NOP -> err=1 stays set, cmd_count=2, no px_valid.
REQ-035 SHALL verify: halt=1 raised mid-RECT -> the RECT completes; q_re stays 0 while halt=1 and q_empty=0, and fetching resumes 1 cycle after halt falls.
